// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package fetch_pkg;

    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 19;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        RD_NONE   = 3'd0,
        RD_BRANCH = 3'd1,
        RD_JUMP   = 3'd2,
        RD_CALL   = 3'd3,
        RD_RET    = 3'd4
    } redirect_t;

    // Sign-extend an 8-bit branch word offset to the PC width.
    function automatic addr_t sext_offset(input logic [7:0] off);
        return {{(ADDR_W-8){off[7]}}, off};
    endfunction

endpackage

// File: rtl/return_stack.sv
// Pointer-based return-address stack. A push while full or a pop while
// empty is ignored here; the caller decides what those events mean.
module return_stack
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  addr_t push_data,
    output addr_t top,
    output logic  full,
    output logic  empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [PW:0]   r_count;
    addr_t         r_mem [DEPTH];
    logic [PW:0]   w_count_dec;
    logic [PW-1:0] w_top_idx;

    assign w_count_dec = r_count - {{PW{1'b0}}, 1'b1};
    assign w_top_idx   = w_count_dec[PW-1:0];
    assign full        = (r_count == FULL_CNT);
    assign empty       = (r_count == {(PW+1){1'b0}});
    assign top         = empty ? {ADDR_W{1'b0}} : r_mem[w_top_idx];

    // Stack storage and occupancy count; reset wipes contents too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= {(PW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {ADDR_W{1'b0}};
            end
        end else if (push && !full) begin
            r_mem[r_count[PW-1:0]] <= push_data;
            r_count                <= r_count + {{PW{1'b0}}, 1'b1};
        end else if (pop && !empty) begin
            r_count <= w_count_dec;
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, redirect handling with a single
// bubble, IF/ID pipeline register and a return-address stack.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter addr_t RESET_PC    = 12'd0,
    parameter int    STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [7:0]  branch_offset,
    input  logic        jump,
    input  logic        call,
    input  logic        ret,
    input  logic [11:0] jump_target,
    output logic [11:0] imem_addr,
    input  logic [18:0] imem_instr,
    output logic [18:0] id_instr,
    output logic [11:0] id_pc,
    output logic        id_valid,
    output logic        stack_overflow,
    output logic        stack_underflow
);

    addr_t               r_pc;
    logic [INSTR_W-1:0]  r_id_instr;
    addr_t               r_id_pc;
    logic                r_id_valid;
    logic                r_ovf;
    logic                r_unf;

    logic      w_accept;
    redirect_t w_redirect;
    addr_t     w_next_pc;
    logic      w_push;
    logic      w_pop;
    addr_t     w_push_data;
    addr_t     w_stack_top;
    logic      w_stack_full;
    logic      w_stack_empty;

    // Redirects only act on a real instruction sitting in IF/ID while decode advances.
    assign w_accept    = !stall && r_id_valid;
    assign w_push      = (w_redirect == RD_CALL);
    assign w_pop       = (w_redirect == RD_RET);
    assign w_push_data = r_id_pc + 12'd1;

    return_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_push_data),
        .top       (w_stack_top),
        .full      (w_stack_full),
        .empty     (w_stack_empty)
    );

    // Redirect priority encoder: call > jump > ret > branch.
    always_comb begin
        w_redirect = RD_NONE;
        if (w_accept) begin
            if (call) begin
                w_redirect = RD_CALL;
            end else if (jump) begin
                w_redirect = RD_JUMP;
            end else if (ret) begin
                w_redirect = RD_RET;
            end else if (branch_taken) begin
                w_redirect = RD_BRANCH;
            end else begin
                w_redirect = RD_NONE;
            end
        end else begin
            w_redirect = RD_NONE;
        end
    end

    // Next-PC mux; a pop from an empty stack falls back to the reset vector.
    always_comb begin
        w_next_pc = r_pc + 12'd1;
        case (w_redirect)
            RD_NONE:   w_next_pc = r_pc + 12'd1;
            RD_BRANCH: w_next_pc = r_id_pc + 12'd1 + sext_offset(branch_offset);
            RD_JUMP:   w_next_pc = jump_target;
            RD_CALL:   w_next_pc = jump_target;
            RD_RET: begin
                if (w_stack_empty) begin
                    w_next_pc = RESET_PC;
                end else begin
                    w_next_pc = w_stack_top;
                end
            end
            default:   w_next_pc = r_pc + 12'd1;
        endcase
    end

    // PC, IF/ID register and sticky stack flags; stall freezes all of them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_id_instr <= {INSTR_W{1'b0}};
            r_id_pc    <= {ADDR_W{1'b0}};
            r_id_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else if (stall) begin
            r_pc       <= r_pc;
            r_id_instr <= r_id_instr;
            r_id_pc    <= r_id_pc;
            r_id_valid <= r_id_valid;
            r_ovf      <= r_ovf;
            r_unf      <= r_unf;
        end else begin
            r_pc       <= w_next_pc;
            r_id_instr <= imem_instr;
            r_id_pc    <= r_pc;
            // The word fetched alongside an accepted redirect is squashed.
            r_id_valid <= (w_redirect == RD_NONE);
            r_ovf      <= r_ovf | (w_push & w_stack_full);
            r_unf      <= r_unf | (w_pop & w_stack_empty);
        end
    end

    assign imem_addr       = r_pc;
    assign id_instr        = r_id_instr;
    assign id_pc           = r_id_pc;
    assign id_valid        = r_id_valid;
    assign stack_overflow  = r_ovf;
    assign stack_underflow = r_unf;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// multi-cycle sequences, then randomized stimulus against a reference model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_offset;
    logic        jump;
    logic        call;
    logic        ret;
    logic [11:0] jump_target;

    logic [11:0] a_addr, b_addr;
    logic [18:0] a_imem, b_imem;
    logic [18:0] a_instr, b_instr;
    logic [11:0] a_idpc, b_idpc;
    logic        a_valid, b_valid;
    logic        a_ovf, b_ovf;
    logic        a_unf, b_unf;

    int n_checks;
    int n_errors;

    function automatic logic [18:0] mem_word(input logic [11:0] a);
        return {a[6:0], a};
    endfunction

    assign a_imem = mem_word(a_addr);
    assign b_imem = mem_word(b_addr);

    fetch_unit #(.RESET_PC(12'd0), .STACK_DEPTH(8)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .call(call), .ret(ret),
        .jump_target(jump_target), .imem_addr(a_addr), .imem_instr(a_imem),
        .id_instr(a_instr), .id_pc(a_idpc), .id_valid(a_valid),
        .stack_overflow(a_ovf), .stack_underflow(a_unf)
    );

    fetch_unit #(.RESET_PC(12'hFFE), .STACK_DEPTH(8)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .call(call), .ret(ret),
        .jump_target(jump_target), .imem_addr(b_addr), .imem_instr(b_imem),
        .id_instr(b_instr), .id_pc(b_idpc), .id_valid(b_valid),
        .stack_overflow(b_ovf), .stack_underflow(b_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [7:0]  off;
        logic        jmp;
        logic        cal;
        logic        rt;
        logic [11:0] tgt;
        logic        ev;
        logic [11:0] epc;
        logic [11:0] eaddr;
    } vec_t;

    vec_t tbl[18];

    // Reference model state (behavioural, spec-level).
    logic [11:0] m_pc, m_idpc;
    logic [18:0] m_instr;
    logic        m_v, m_ovf, m_unf;
    logic [11:0] m_stk[$];

    function automatic vec_t mk(input logic b, input logic [7:0] o, input logic ev,
                                input logic [11:0] epc, input logic [11:0] eaddr);
        vec_t v;
        v.stall = 1'b0; v.br = b; v.off = o; v.jmp = 1'b0; v.cal = 1'b0; v.rt = 1'b0;
        v.tgt = 12'd0; v.ev = ev; v.epc = epc; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        stall = 1'b0; branch_taken = 1'b0; branch_offset = 8'd0;
        jump = 1'b0; call = 1'b0; ret = 1'b0; jump_target = 12'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", 32'(a_addr), 32'd0);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_idpc", 32'(a_idpc), 32'd0);
        chk("rst_instr", 32'(a_instr), 32'd0);
        chk("rst_flags", 32'({a_ovf, a_unf}), 32'd0);
        chk("rst_addr_b", 32'(b_addr), 32'hFFE);
        rst = 1'b0;
        m_pc = 12'd0; m_idpc = 12'd0; m_instr = 19'd0;
        m_v = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        m_stk.delete();
    endtask

    // Advance the reference model by one clock using the current inputs.
    task automatic model_step();
        logic [11:0] tgt;
        logic [11:0] ra;
        logic        redir;
        if (!stall) begin
            redir = m_v && (call || jump || ret || branch_taken);
            tgt = 12'd0;
            if (m_v) begin
                if (call) begin
                    tgt = jump_target;
                    ra = m_idpc + 12'd1;
                    if (m_stk.size() < 8) m_stk.push_back(ra);
                    else m_ovf = 1'b1;
                end else if (jump) begin
                    tgt = jump_target;
                end else if (ret) begin
                    if (m_stk.size() > 0) tgt = m_stk.pop_back();
                    else begin
                        tgt = 12'd0;
                        m_unf = 1'b1;
                    end
                end else if (branch_taken) begin
                    tgt = 12'(int'(m_idpc) + 1 + int'($signed(branch_offset)));
                end
            end
            m_instr = mem_word(m_pc);
            m_idpc  = m_pc;
            m_v     = !redir;
            m_pc    = redir ? tgt : m_pc + 12'd1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clear_inputs();

        // ---------------- Directed vector table ----------------
        for (int i = 0; i <= 10; i++) tbl[i] = mk(1'b0, 8'd0, 1'b1, 12'(i), 12'(i + 1));
        tbl[11] = mk(1'b1, 8'hFC, 1'b0, 12'd0, 12'd7);    // branch -4 from id_pc 10
        tbl[12] = mk(1'b0, 8'd0, 1'b1, 12'd7, 12'd8);
        tbl[13] = mk(1'b0, 8'd0, 1'b1, 12'd8, 12'd9);
        tbl[14] = mk(1'b0, 8'd0, 1'b1, 12'd9, 12'd10);
        tbl[15] = mk(1'b0, 8'd0, 1'b1, 12'd10, 12'd11);
        tbl[16] = mk(1'b1, 8'd5, 1'b0, 12'd0, 12'd16);    // branch +5 from id_pc 10
        tbl[17] = mk(1'b0, 8'd0, 1'b1, 12'd16, 12'd17);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            stall = tbl[i].stall; branch_taken = tbl[i].br; branch_offset = tbl[i].off;
            jump = tbl[i].jmp; call = tbl[i].cal; ret = tbl[i].rt; jump_target = tbl[i].tgt;
            tick();
            chk($sformatf("tbl%0d_valid", i), 32'(a_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_addr", i), 32'(a_addr), 32'(tbl[i].eaddr));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_idpc", i), 32'(a_idpc), 32'(tbl[i].epc));
                chk($sformatf("tbl%0d_instr", i), 32'(a_instr), 32'(mem_word(tbl[i].epc)));
            end
            if (i < 3) begin
                chk($sformatf("wrap%0d_addr", i), 32'(b_addr), 32'(12'(12'hFFE + i + 1)));
                chk($sformatf("wrap%0d_idpc", i), 32'(b_idpc), 32'(12'(12'hFFE + i)));
                chk($sformatf("wrap%0d_valid", i), 32'(b_valid), 32'd1);
            end
        end
        clear_inputs();

        // ---------------- call at 20 then ret ----------------
        do_reset();
        repeat (21) tick();
        chk("cr_idpc20", 32'(a_idpc), 32'd20);
        call = 1'b1; jump_target = 12'd100;
        tick();
        chk("cr_bubble", 32'(a_valid), 32'd0);
        chk("cr_addr100", 32'(a_addr), 32'd100);
        clear_inputs();
        tick();
        chk("cr_idpc100", 32'(a_idpc), 32'd100);
        chk("cr_valid100", 32'(a_valid), 32'd1);
        tick();
        ret = 1'b1;
        tick();
        chk("cr_ret_bubble", 32'(a_valid), 32'd0);
        clear_inputs();
        tick();
        chk("cr_ret_idpc", 32'(a_idpc), 32'd21);
        chk("cr_ret_valid", 32'(a_valid), 32'd1);
        chk("cr_flags", 32'({a_ovf, a_unf}), 32'd0);

        // ---------------- nine nested calls, unwind, underflow ----------------
        do_reset();
        tick();
        for (int i = 0; i < 9; i++) begin
            call = 1'b1; jump_target = 12'(200 + 10 * i);
            tick();
            call = 1'b0;
            tick();
            chk($sformatf("nest%0d_idpc", i), 32'(a_idpc), 32'(200 + 10 * i));
            chk($sformatf("nest%0d_ovf", i), 32'(a_ovf), (i == 8) ? 32'd1 : 32'd0);
        end
        for (int j = 0; j < 8; j++) begin
            ret = 1'b1;
            tick();
            ret = 1'b0;
            chk($sformatf("unwind%0d_addr", j), 32'(a_addr),
                (j < 7) ? 32'(200 + 10 * (6 - j) + 1) : 32'd1);
            tick();
        end
        chk("unwind_unf0", 32'(a_unf), 32'd0);
        ret = 1'b1;
        tick();
        ret = 1'b0;
        chk("empty_ret_addr", 32'(a_addr), 32'd0);
        chk("empty_ret_unf", 32'(a_unf), 32'd1);
        chk("empty_ret_ovf_sticky", 32'(a_ovf), 32'd1);
        tick();

        // ---------------- stall with branch held ----------------
        do_reset();
        repeat (5) tick();
        stall = 1'b1; branch_taken = 1'b1; branch_offset = 8'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d_addr", k), 32'(a_addr), 32'd5);
            chk($sformatf("stall%0d_idpc", k), 32'(a_idpc), 32'd4);
            chk($sformatf("stall%0d_valid", k), 32'(a_valid), 32'd1);
        end
        stall = 1'b0;
        tick();
        chk("unstall_bubble", 32'(a_valid), 32'd0);
        chk("unstall_addr", 32'(a_addr), 32'd8);
        clear_inputs();
        tick();
        chk("unstall_idpc", 32'(a_idpc), 32'd8);

        // ---------------- reset asserted mid-stall ----------------
        do_reset();
        tick();
        ret = 1'b1;                       // underflow sets a flag
        tick();
        ret = 1'b0;
        tick();
        call = 1'b1; jump_target = 12'd300;  // leaves one stack entry
        tick();
        call = 1'b0;
        repeat (2) tick();
        stall = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(a_valid), 32'd0);
        chk("mid_rst_addr", 32'(a_addr), 32'd0);
        chk("mid_rst_flags", 32'({a_ovf, a_unf}), 32'd0);
        do_reset();
        tick();
        ret = 1'b1;                       // stack must have been emptied
        tick();
        ret = 1'b0;
        chk("post_rst_ret_addr", 32'(a_addr), 32'd0);
        chk("post_rst_ret_unf", 32'(a_unf), 32'd1);

        // ---------------- randomized vs reference model ----------------
        do_reset();
        for (int c = 0; c < 600; c++) begin
            int r;
            stall = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 15);
            call = (r == 0) || (r == 7);
            jump = (r == 1) || (r == 7);
            ret = (r == 2) || (r == 3) || (r == 7);
            branch_taken = (r >= 4 && r <= 7);
            branch_offset = 8'($urandom);
            jump_target = 12'($urandom);
            model_step();
            tick();
            chk("rnd_addr", 32'(a_addr), 32'(m_pc));
            chk("rnd_valid", 32'(a_valid), 32'(m_v));
            chk("rnd_flags", 32'({a_ovf, a_unf}), 32'({m_ovf, m_unf}));
            if (m_v) begin
                chk("rnd_idpc", 32'(a_idpc), 32'(m_idpc));
                chk("rnd_instr", 32'(a_instr), 32'(m_instr));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
